rrd_pipe_stage: RTL
===================

Name: rrd_pipe_stage

Overview:
- Parametrised multi-channel register-read pipeline stage that sits between the issue units and the execution units.
- Generalises the single-slot combinational pass-through to NUM_CH independent channels, each LATENCY entries deep, with the following per-channel features:
  - valid/ready backpressure with bubble collapsing
  - branch-mask resolve and mispredict kill
  - pipeline flush
  - immediate zeroing at capture
  - occupancy and kill performance counters

Parameters:
NUM_CH, 2, number of independent issue channels (1..4)
LATENCY, 2, register stages per channel (1..4)
BR_W, 20, branch-mask width
PAY_W, 64, opaque uop payload width (rob_idx, pdst, prs*, rtypes, ...), passed unmodified
CNT_W, 16, kill-counter width

Ports:
clock  in  1  sole clock
reset  in  1  synchronous active-high reset
io_iss_valid  in  NUM_CH  per-channel uop valid
io_iss_ready  out  NUM_CH  per-channel accept
io_iss_uopc  in  7*NUM_CH  micro-op code per channel
io_iss_mem_cmd  in  5*NUM_CH  memory command
io_iss_br_mask  in  BR_W*NUM_CH  branch dependency mask
io_iss_imm_packed  in  20*NUM_CH  packed immediate
io_iss_payload  in  PAY_W*NUM_CH  opaque payload
io_brupdate_resolve_mask  in  BR_W  branches resolved this cycle
io_brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle
io_flush  in  1  kill everything
io_rrd_valid  out  NUM_CH  output uop valid
io_rrd_ready  in  NUM_CH  downstream accept
io_rrd_uopc, io_rrd_mem_cmd, io_rrd_br_mask, io_rrd_imm_packed, io_rrd_payload  out  same widths as inputs  output uop fields
io_occupancy  out  3*NUM_CH  valid entries per channel (0..LATENCY)
io_kill_count  out  CNT_W  saturating count of uops killed by mispredict

Behaviour:
Reset:
- All entry valids clear.
- io_rrd_valid = 0, io_occupancy = 0, io_kill_count = 0.
- io_iss_ready = 1 in the first cycle after reset deasserts.
- Data registers are don't-care.

Pipeline:
- Channel c has stages 0..LATENCY-1; stage LATENCY-1 drives the outputs.
- Latency is exactly LATENCY cycles when unstalled. Full throughput: 1 uop per cycle per channel.
- Stage k advances into k+1 when k+1 is empty or k+1 is advancing (bubble collapse).
- The last stage advances on io_rrd_valid & io_rrd_ready.
- io_iss_ready[c] = stage 0 empty or stage 0 advancing. This is combinational from io_rrd_ready, with no dependency on io_iss_valid.
- Capture occurs on io_iss_valid & io_iss_ready.
- Channels are fully independent; a stall on one never affects another.

Immediate rule (applied at capture):
- io_rrd_imm_packed is stored as 0 when uopc == 7'h43, or when uopc == 7'h01 and mem_cmd == 5'h06.
- Otherwise the immediate is stored unchanged.

Branch resolve:
- Every cycle, every stored br_mask and every incoming captured br_mask is ANDed with ~io_brupdate_resolve_mask.
- Output io_rrd_br_mask = stored mask & ~resolve_mask, applied combinationally.

Mispredict kill:
- A stored entry with (br_mask & mispredict_mask) != 0 is invalidated at the next edge.
- io_rrd_valid is also masked combinationally in the same cycle, so a killed uop never handshakes.
- An incoming uop with a matching mask is accepted (ready unaffected) but not written valid.
- Killed entries free their slot at the next edge.

Kill counter:
- io_kill_count increases by the number of valid entries killed this cycle, stored plus incoming, summed across channels.
- It saturates at 2^CNT_W-1.
- Flush kills are not counted.

Flush:
- io_flush invalidates all stages and incoming captures at the next edge.
- io_rrd_valid is forced to 0 combinationally in the flush cycle.
- io_iss_ready is unaffected.
- Flush has priority over mispredict.

Occupancy:
- io_occupancy is the registered valid-entry count, updated after capture, advance, kill and flush.

Simultaneous events:
- Resolve and mispredict of the same bit in one cycle: mispredict wins, and the entry is killed.
- Output handshake and kill in the same cycle cannot both happen, because valid is masked.
- Reset has priority over everything.

Test Plan:
- Reset, NUM_CH=2, LATENCY=2; issue uopc=7'h10, imm=20'h12345 on ch0 at cycle 0, ready=1 → io_rrd_valid[0]=1 at cycle 2, imm 20'h12345; io_occupancy[0] returns to 0 after handshake.
- Issue uopc=7'h43, imm=20'hABCDE, then uopc=7'h01, mem_cmd=5'h06, imm=20'h00F00 → both output imm 0; uopc=7'h01 with mem_cmd=5'h00 → imm 20'h00F00 preserved.
- Hold io_rrd_ready[0]=0 and stream 4 uops on ch0 → io_iss_ready[0] drops after 2 accepts, occupancy=2; ch1 streaming continues at 1 per cycle; release ready → order preserved, no loss or duplication.
- Two entries with br_mask 20'h00001 and 20'h00002; mispredict_mask=20'h00002 → the second is dropped (valid masked the same cycle), the first is delivered, kill_count=1.
- resolve_mask=20'h00001 on an entry with br_mask 20'h00003 → output br_mask 20'h00002; assert resolve and mispredict of bit0 together → entry killed.
- io_flush with 2 entries per channel and a simultaneous issue → all io_rrd_valid=0 that cycle and the next, occupancy=0, kill_count unchanged; assert reset mid-stall → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/rrd_pipe_stage_if.sv
// Issue-side and execute-side signal bundle for the register-read pipeline stage.
// The master drives issue uops and downstream ready; the slave is the stage itself.
interface rrd_pipe_stage_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned BR_W   = 20,
  parameter int unsigned PAY_W  = 64,
  parameter int unsigned CNT_W  = 16
);
  logic [NUM_CH-1:0]       io_iss_valid;
  logic [NUM_CH-1:0]       io_iss_ready;
  logic [7*NUM_CH-1:0]     io_iss_uopc;
  logic [5*NUM_CH-1:0]     io_iss_mem_cmd;
  logic [BR_W*NUM_CH-1:0]  io_iss_br_mask;
  logic [20*NUM_CH-1:0]    io_iss_imm_packed;
  logic [PAY_W*NUM_CH-1:0] io_iss_payload;

  logic [BR_W-1:0]         io_brupdate_resolve_mask;
  logic [BR_W-1:0]         io_brupdate_mispredict_mask;
  logic                    io_flush;

  logic [NUM_CH-1:0]       io_rrd_valid;
  logic [NUM_CH-1:0]       io_rrd_ready;
  logic [7*NUM_CH-1:0]     io_rrd_uopc;
  logic [5*NUM_CH-1:0]     io_rrd_mem_cmd;
  logic [BR_W*NUM_CH-1:0]  io_rrd_br_mask;
  logic [20*NUM_CH-1:0]    io_rrd_imm_packed;
  logic [PAY_W*NUM_CH-1:0] io_rrd_payload;

  logic [3*NUM_CH-1:0]     io_occupancy;
  logic [CNT_W-1:0]        io_kill_count;

  modport master (
    output io_iss_valid, io_iss_uopc, io_iss_mem_cmd, io_iss_br_mask, io_iss_imm_packed,
           io_iss_payload, io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_flush,
           io_rrd_ready,
    input  io_iss_ready, io_rrd_valid, io_rrd_uopc, io_rrd_mem_cmd, io_rrd_br_mask,
           io_rrd_imm_packed, io_rrd_payload, io_occupancy, io_kill_count
  );

  modport slave (
    input  io_iss_valid, io_iss_uopc, io_iss_mem_cmd, io_iss_br_mask, io_iss_imm_packed,
           io_iss_payload, io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_flush,
           io_rrd_ready,
    output io_iss_ready, io_rrd_valid, io_rrd_uopc, io_rrd_mem_cmd, io_rrd_br_mask,
           io_rrd_imm_packed, io_rrd_payload, io_occupancy, io_kill_count
  );
endinterface

// File: rtl/rrd_pipe_stage.sv
// Multi-channel register-read pipeline: NUM_CH independent LATENCY-deep elastic pipes with
// branch resolve/kill, flush, immediate zeroing at capture and occupancy/kill counters.
module rrd_pipe_stage #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned BR_W    = 20,
  parameter int unsigned PAY_W   = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clock,
  input  logic            reset,
  rrd_pipe_stage_if.slave bus_io
);

  localparam int unsigned NumE = NUM_CH * LATENCY;
  localparam int          Last = int'(LATENCY) - 1;
  localparam int unsigned SumW = CNT_W + 6;

  // Entry e = c * LATENCY + k holds stage k of channel c.
  function automatic int ix(int c, int k);
    return c * int'(LATENCY) + k;
  endfunction

  function automatic logic zero_imm(logic [6:0] uopc, logic [4:0] mem_cmd);
    return (uopc == 7'h43) || ((uopc == 7'h01) && (mem_cmd == 5'h06));
  endfunction

  logic             valid_q [NumE];
  logic             valid_d [NumE];
  logic [6:0]       uopc_q  [NumE];
  logic [6:0]       uopc_d  [NumE];
  logic [4:0]       mem_q   [NumE];
  logic [4:0]       mem_d   [NumE];
  logic [BR_W-1:0]  br_q    [NumE];
  logic [BR_W-1:0]  br_d    [NumE];
  logic [19:0]      imm_q   [NumE];
  logic [19:0]      imm_d   [NumE];
  logic [PAY_W-1:0] pay_q   [NumE];
  logic [PAY_W-1:0] pay_d   [NumE];

  logic [2:0]       occ_q   [NUM_CH];
  logic [2:0]       occ_d   [NUM_CH];
  logic [CNT_W-1:0] kill_cnt_q;
  logic [CNT_W-1:0] kill_cnt_d;

  logic              kill [NumE];
  logic              move [NumE];
  logic [NUM_CH-1:0] iss_ready;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] in_kill;
  logic [SumW-1:0]   kill_sum;
  logic [SumW-1:0]   kill_total;

  // Advance chain, walked from the output stage backwards. Flush is deliberately left out so
  // issue-side ready does not depend on it; a flush clears every capture anyway.
  always_comb begin
    kill      = '{default: 1'b0};
    move      = '{default: 1'b0};
    iss_ready = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      for (int k = Last; k >= 0; k--) begin
        kill[ix(c, k)] = valid_q[ix(c, k)] &
                         (|(br_q[ix(c, k)] & bus_io.io_brupdate_mispredict_mask));
        if (k == Last) begin
          move[ix(c, k)] = valid_q[ix(c, k)] & ~kill[ix(c, k)] & bus_io.io_rrd_ready[c];
        end else begin
          move[ix(c, k)] = valid_q[ix(c, k)] & (~valid_q[ix(c, k + 1)] | move[ix(c, k + 1)]);
        end
      end
      iss_ready[c] = ~valid_q[ix(c, 0)] | move[ix(c, 0)];
    end
  end

  always_comb begin
    valid_d  = '{default: 1'b0};
    uopc_d   = uopc_q;
    mem_d    = mem_q;
    br_d     = br_q;
    imm_d    = imm_q;
    pay_d    = pay_q;
    occ_d    = '{default: 3'd0};
    cap      = '0;
    in_kill  = '0;
    kill_sum = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      cap[c]     = bus_io.io_iss_valid[c] & iss_ready[c];
      in_kill[c] = |(bus_io.io_iss_br_mask[c*BR_W +: BR_W] & bus_io.io_brupdate_mispredict_mask);
      for (int k = 0; k <= Last; k++) begin
        valid_d[ix(c, k)] = valid_q[ix(c, k)] & ~kill[ix(c, k)] & ~move[ix(c, k)];
        br_d[ix(c, k)]    = br_q[ix(c, k)] & ~bus_io.io_brupdate_resolve_mask;
        if (k == 0) begin
          if (cap[c]) begin
            valid_d[ix(c, k)] = ~in_kill[c];
            uopc_d[ix(c, k)]  = bus_io.io_iss_uopc[c*7 +: 7];
            mem_d[ix(c, k)]   = bus_io.io_iss_mem_cmd[c*5 +: 5];
            br_d[ix(c, k)]    = bus_io.io_iss_br_mask[c*BR_W +: BR_W] &
                                ~bus_io.io_brupdate_resolve_mask;
            imm_d[ix(c, k)]   = zero_imm(bus_io.io_iss_uopc[c*7 +: 7],
                                         bus_io.io_iss_mem_cmd[c*5 +: 5]) ?
                                20'h0 : bus_io.io_iss_imm_packed[c*20 +: 20];
            pay_d[ix(c, k)]   = bus_io.io_iss_payload[c*PAY_W +: PAY_W];
          end
        end else if (move[ix(c, k - 1)]) begin
          valid_d[ix(c, k)] = valid_q[ix(c, k - 1)] & ~kill[ix(c, k - 1)];
          uopc_d[ix(c, k)]  = uopc_q[ix(c, k - 1)];
          mem_d[ix(c, k)]   = mem_q[ix(c, k - 1)];
          br_d[ix(c, k)]    = br_q[ix(c, k - 1)] & ~bus_io.io_brupdate_resolve_mask;
          imm_d[ix(c, k)]   = imm_q[ix(c, k - 1)];
          pay_d[ix(c, k)]   = pay_q[ix(c, k - 1)];
        end
        kill_sum = kill_sum + SumW'(kill[ix(c, k)]);
      end
      kill_sum = kill_sum + SumW'(cap[c] & in_kill[c]);
    end

    // Flush drops everything and its victims are not counted as mispredict kills.
    if (bus_io.io_flush) begin
      valid_d  = '{default: 1'b0};
      kill_sum = '0;
    end

    for (int c = 0; c < int'(NUM_CH); c++) begin
      for (int k = 0; k <= Last; k++) begin
        occ_d[c] = occ_d[c] + 3'(valid_d[ix(c, k)]);
      end
    end

    kill_total = SumW'(kill_cnt_q) + kill_sum;
    kill_cnt_d = (|kill_total[SumW-1:CNT_W]) ? '1 : kill_total[CNT_W-1:0];
  end

  always_comb begin
    bus_io.io_iss_ready      = iss_ready;
    bus_io.io_rrd_valid      = '0;
    bus_io.io_rrd_uopc       = '0;
    bus_io.io_rrd_mem_cmd    = '0;
    bus_io.io_rrd_br_mask    = '0;
    bus_io.io_rrd_imm_packed = '0;
    bus_io.io_rrd_payload    = '0;
    bus_io.io_occupancy      = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      // Killed or flushed uops are hidden in the same cycle so they can never handshake.
      bus_io.io_rrd_valid[c]            = valid_q[ix(c, Last)] & ~kill[ix(c, Last)] &
                                          ~bus_io.io_flush;
      bus_io.io_rrd_uopc[c*7 +: 7]      = uopc_q[ix(c, Last)];
      bus_io.io_rrd_mem_cmd[c*5 +: 5]   = mem_q[ix(c, Last)];
      bus_io.io_rrd_br_mask[c*BR_W +: BR_W] = br_q[ix(c, Last)] &
                                              ~bus_io.io_brupdate_resolve_mask;
      bus_io.io_rrd_imm_packed[c*20 +: 20]  = imm_q[ix(c, Last)];
      bus_io.io_rrd_payload[c*PAY_W +: PAY_W] = pay_q[ix(c, Last)];
      bus_io.io_occupancy[c*3 +: 3]     = occ_q[c];
    end
    bus_io.io_kill_count = kill_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '{default: 1'b0};
      occ_q      <= '{default: 3'd0};
      kill_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    uopc_q <= uopc_d;
    mem_q  <= mem_d;
    br_q   <= br_d;
    imm_q  <= imm_d;
    pay_q  <= pay_d;
  end

endmodule
